rtc_bus_arbiter: RTL

RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

---
 rtl/rtc_bus_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - arbitrates clear/write/read engines onto a multiplexed RTC address/data bus
// Each grant runs one fixed-timing address phase then one data phase, ending in a gap with the ack.
module rtc_bus_arbiter #(
    parameter int T_PULSE = 2,
    parameter int T_HOLD  = 1,
    parameter int T_GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_clr,
    input  logic       req_wr,
    input  logic       req_rd,
    input  logic [7:0] clr_addr,
    input  logic [7:0] clr_data,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic       ack_clr,
    output logic       ack_wr,
    output logic       ack_rd,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       AD,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in
);

    // Zero-length phases are promoted to one cycle.
    localparam int P_LEN  = (T_PULSE < 1) ? 1 : T_PULSE;
    localparam int H_LEN  = (T_HOLD  < 1) ? 1 : T_HOLD;
    localparam int G_LEN  = (T_GAP   < 1) ? 1 : T_GAP;
    localparam int MAX_PH = (P_LEN > H_LEN) ? ((P_LEN > G_LEN) ? P_LEN : G_LEN)
                                            : ((H_LEN > G_LEN) ? H_LEN : G_LEN);
    localparam int CW     = (MAX_PH < 2) ? 1 : $clog2(MAX_PH);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, GAP
    } state_t;

    typedef enum logic [1:0] {
        OP_CLR, OP_WR, OP_RD
    } op_t;

    state_t        state, state_n;
    op_t           op, op_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    addr_q, addr_n;
    logic [7:0]    data_q, data_n;
    logic          last_rd, last_rd_n;
    logic          phase_end;
    logic          is_rd_n;
    int            phase_len;

    always_comb begin
        case (state)
            A_STROBE, D_STROBE: phase_len = P_LEN;
            A_HOLD, D_HOLD:     phase_len = H_LEN;
            GAP:                phase_len = G_LEN;
            default:            phase_len = 1;
        endcase
    end

    assign phase_end = (cnt == CW'(phase_len - 1));
    assign is_rd_n   = (op_n == OP_RD);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        op_n      = op;
        addr_n    = addr_q;
        data_n    = data_q;
        last_rd_n = last_rd;
        if (state == IDLE) begin
            cnt_n = '0;
            // Clear always wins; write and read alternate when both wait.
            if (req_clr) begin
                op_n    = OP_CLR;
                addr_n  = clr_addr;
                data_n  = clr_data;
                state_n = A_SETUP;
            end else if (req_wr && (!req_rd || last_rd)) begin
                op_n      = OP_WR;
                addr_n    = wr_addr;
                data_n    = wr_data;
                last_rd_n = 1'b0;
                state_n   = A_SETUP;
            end else if (req_rd) begin
                op_n      = OP_RD;
                addr_n    = rd_addr;
                last_rd_n = 1'b1;
                state_n   = A_SETUP;
            end
        end else if (phase_end) begin
            cnt_n = '0;
            case (state)
                A_SETUP:  state_n = A_STROBE;
                A_STROBE: state_n = A_HOLD;
                A_HOLD:   state_n = D_SETUP;
                D_SETUP:  state_n = D_STROBE;
                D_STROBE: state_n = D_HOLD;
                D_HOLD:   state_n = GAP;
                default:  state_n = IDLE;
            endcase
        end else begin
            cnt_n = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            op      <= OP_CLR;
            cnt     <= '0;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            last_rd <= 1'b1;
            busy    <= 1'b0;
            ack_clr <= 1'b0;
            ack_wr  <= 1'b0;
            ack_rd  <= 1'b0;
            rd_data <= 8'h00;
            AD      <= 1'b1;
            CS      <= 1'b1;
            RD      <= 1'b1;
            WR      <= 1'b1;
            bus_oe  <= 1'b0;
            bus_out <= 8'h00;
        end else begin
            state   <= state_n;
            op      <= op_n;
            cnt     <= cnt_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            last_rd <= last_rd_n;
            busy    <= (state_n != IDLE);
            ack_clr <= (state_n == GAP) && (state != GAP) && (op == OP_CLR);
            ack_wr  <= (state_n == GAP) && (state != GAP) && (op == OP_WR);
            ack_rd  <= (state_n == GAP) && (state != GAP) && (op == OP_RD);
            if (state == D_STROBE && phase_end && op == OP_RD)
                rd_data <= bus_in;
            // Bus controls are decoded from the state being entered so they are registered.
            case (state_n)
                A_SETUP, A_STROBE, A_HOLD: begin
                    AD      <= 1'b0;
                    CS      <= 1'b0;
                    RD      <= 1'b1;
                    WR      <= (state_n != A_STROBE);
                    bus_oe  <= 1'b1;
                    bus_out <= addr_n;
                end
                D_SETUP, D_STROBE, D_HOLD: begin
                    AD     <= 1'b1;
                    CS     <= 1'b0;
                    RD     <= !((state_n == D_STROBE) && is_rd_n);
                    WR     <= !((state_n == D_STROBE) && !is_rd_n);
                    bus_oe <= !is_rd_n;
                    if (!is_rd_n)
                        bus_out <= data_n;
                end
                default: begin
                    AD     <= 1'b1;
                    CS     <= 1'b1;
                    RD     <= 1'b1;
                    WR     <= 1'b1;
                    bus_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule
